// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Serves dispatcher operand queries combinationally and absorbs the RoB commit stream.
module register_file #(
  parameter int REG_WIDTH    = 5,
  parameter int EX_REG_WIDTH = 6,
  parameter int NON_REG      = 32,
  parameter int RoB_WIDTH    = 4,
  parameter int EX_RoB_WIDTH = 5,
  parameter int NON_DEP      = 16
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
  output logic [31:0]             RFDP_Vj,
  output logic [31:0]             RFDP_Vk,
  input  logic                    DPRF_en,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
  input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
  input  logic                    RoBRF_pre_judge,
  input  logic                    RoBRF_en,
  input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  input  logic [31:0]             RoBRF_value
);

  localparam int unsigned NUM_REGS = 2 ** REG_WIDTH;
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP_TAG  = EX_RoB_WIDTH'(NON_DEP);
  localparam logic [EX_REG_WIDTH-1:0] NON_REG_CODE = EX_REG_WIDTH'(NON_REG);

  logic [31:0]             value_q [NUM_REGS];
  logic [EX_RoB_WIDTH-1:0] tag_q   [NUM_REGS];

  logic [REG_WIDTH-1:0]    rs1_idx, rs2_idx, cm_idx, rn_idx;
  logic [EX_RoB_WIDTH-1:0] cm_tag, rn_tag;
  logic                    cm_valid, rn_valid;

  // x0, NON_REG and any out-of-range code all mean "no register".
  function automatic logic reg_valid(input logic [EX_REG_WIDTH-1:0] r);
    return (r != NON_REG_CODE) &&
           (r[EX_REG_WIDTH-1:REG_WIDTH] == '0) &&
           (r[REG_WIDTH-1:0] != '0);
  endfunction

  function automatic logic [EX_RoB_WIDTH+31:0] lookup(
    input logic [EX_REG_WIDTH-1:0] rs,
    input logic [EX_RoB_WIDTH-1:0] tag,
    input logic [31:0]             val,
    input logic                    c_en,
    input logic [EX_REG_WIDTH-1:0] c_rd,
    input logic [EX_RoB_WIDTH-1:0] c_tag,
    input logic [31:0]             c_val
  );
    logic [EX_RoB_WIDTH-1:0] q;
    logic [31:0]             v;
    q = NON_DEP_TAG;
    v = '0;
    if (reg_valid(rs)) begin
      if (tag == NON_DEP_TAG) begin
        v = val;
      end else if (c_en && (c_rd == rs) && (tag == c_tag)) begin
        v = c_val;
      end else begin
        q = tag;
      end
    end
    return {q, v};
  endfunction

  always_comb begin
    rs1_idx  = DPRF_rs1[REG_WIDTH-1:0];
    rs2_idx  = DPRF_rs2[REG_WIDTH-1:0];
    cm_idx   = RoBRF_rd[REG_WIDTH-1:0];
    rn_idx   = DPRF_rd[REG_WIDTH-1:0];
    cm_tag   = EX_RoB_WIDTH'(RoBRF_RoB_index);
    rn_tag   = EX_RoB_WIDTH'(DPRF_RoB_index);
    cm_valid = RoBRF_en && reg_valid(RoBRF_rd);
    rn_valid = DPRF_en && RoBRF_pre_judge && reg_valid(DPRF_rd);
    {RFDP_Qj, RFDP_Vj} = lookup(DPRF_rs1, tag_q[rs1_idx], value_q[rs1_idx],
                                RoBRF_en, RoBRF_rd, cm_tag, RoBRF_value);
    {RFDP_Qk, RFDP_Vk} = lookup(DPRF_rs2, tag_q[rs2_idx], value_q[rs2_idx],
                                RoBRF_en, RoBRF_rd, cm_tag, RoBRF_value);
  end

  // Later assignments take priority: flush, then commit tag clear, then rename.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NON_DEP_TAG;
      end
    end else if (Sys_rdy) begin
      if (!RoBRF_pre_judge) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          tag_q[i] <= NON_DEP_TAG;
        end
      end
      if (cm_valid) begin
        value_q[cm_idx] <= RoBRF_value;
        if (RoBRF_pre_judge && (tag_q[cm_idx] == cm_tag)) begin
          tag_q[cm_idx] <= NON_DEP_TAG;
        end
      end
      if (rn_valid) begin
        tag_q[rn_idx] <= rn_tag;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected query results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_file;

  localparam logic [5:0] NR = 6'd32;
  localparam logic [4:0] ND = 5'd16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [5:0]  rs1, rs2;
  logic [4:0]  Qj, Qk;
  logic [31:0] Vj, Vk;
  logic        dp_en;
  logic [5:0]  dp_rd;
  logic [3:0]  dp_idx;
  logic        pj, rob_en;
  logic [3:0]  rob_idx;
  logic [5:0]  rob_rd;
  logic [31:0] rob_val;
  logic        chk;

  typedef struct {
    string       name;
    logic [4:0]  qj;
    logic [31:0] vj;
    logic [4:0]  qk;
    logic [31:0] vk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  register_file dut (
    .Sys_clk        (clk),
    .Sys_rst        (rst),
    .Sys_rdy        (rdy),
    .DPRF_rs1       (rs1),
    .DPRF_rs2       (rs2),
    .RFDP_Qj        (Qj),
    .RFDP_Qk        (Qk),
    .RFDP_Vj        (Vj),
    .RFDP_Vk        (Vk),
    .DPRF_en        (dp_en),
    .DPRF_rd        (dp_rd),
    .DPRF_RoB_index (dp_idx),
    .RoBRF_pre_judge(pj),
    .RoBRF_en       (rob_en),
    .RoBRF_RoB_index(rob_idx),
    .RoBRF_rd       (rob_rd),
    .RoBRF_value    (rob_val)
  );

  task automatic defaults();
    rst = 1'b0; rdy = 1'b1; pj = 1'b1;
    dp_en = 1'b0; dp_rd = NR; dp_idx = '0;
    rob_en = 1'b0; rob_idx = '0; rob_rd = NR; rob_val = '0;
    rs1 = NR; rs2 = NR; chk = 1'b0;
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic rename(input logic [5:0] rd, input logic [3:0] idx);
    dp_en = 1'b1; dp_rd = rd; dp_idx = idx;
  endtask

  task automatic commit(input logic [3:0] idx, input logic [5:0] rd, input logic [31:0] val);
    rob_en = 1'b1; rob_idx = idx; rob_rd = rd; rob_val = val;
  endtask

  task automatic query(input string name, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [4:0] eqj, input logic [31:0] evj,
                       input logic [4:0] eqk, input logic [31:0] evk);
    exp_t e;
    rs1 = r1; rs2 = r2;
    e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
    sb.push_back(e);
    chk = 1'b1;
  endtask

  // Monitor: consumes one expectation per flagged cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL monitor: output presented with empty scoreboard");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({Qj, Vj, Qk, Vk} !== {e.qj, e.vj, e.qk, e.vk}) begin
            bad++;
            $display("FAIL %s: got Qj=%0d Vj=%h Qk=%0d Vk=%h, want Qj=%0d Vj=%h Qk=%0d Vk=%h",
                     e.name, Qj, Vj, Qk, Vk, e.qj, e.vj, e.qk, e.vk);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    rst = 1'b1; rdy = 1'b0;
    // reset must act even with Sys_rdy low
    start_cycle(); rst = 1'b1; rdy = 1'b0;
    start_cycle(); query("reset", 6'd5, 6'd0, ND, 32'h0, ND, 32'h0);

    start_cycle(); rename(6'd5, 4'd3); query("rename_not_seen", 6'd5, 6'd0, ND, 32'h0, ND, 32'h0);
    start_cycle(); query("tag_x5", 6'd5, 6'd6, 5'd3, 32'h0, ND, 32'h0);
    start_cycle(); commit(4'd3, 6'd5, 32'h1234); query("commit_bypass_x5", 6'd5, 6'd6, ND, 32'h1234, ND, 32'h0);
    start_cycle(); query("committed_x5", 6'd5, NR, ND, 32'h1234, ND, 32'h0);

    start_cycle(); rename(6'd7, 4'd3);
    start_cycle(); commit(4'd3, 6'd7, 32'hAA); query("bypass_x7", 6'd7, 6'd7, ND, 32'hAA, ND, 32'hAA);
    start_cycle(); query("committed_x7", 6'd7, 6'd5, ND, 32'hAA, ND, 32'h1234);

    start_cycle(); rename(6'd7, 4'd3);
    start_cycle(); rename(6'd7, 4'd4);
    start_cycle(); commit(4'd3, 6'd7, 32'hBB); query("old_commit_no_bypass", 6'd7, NR, 5'd4, 32'h0, ND, 32'h0);
    start_cycle(); query("younger_tag_kept", 6'd7, NR, 5'd4, 32'h0, ND, 32'h0);

    start_cycle(); rename(6'd9, 4'd5);
    start_cycle(); rename(6'd9, 4'd6); commit(4'd5, 6'd9, 32'h55);
                   query("same_cycle_bypass_x9", 6'd9, NR, ND, 32'h55, ND, 32'h0);
    start_cycle(); query("rename_wins_x9", 6'd9, NR, 5'd6, 32'h0, ND, 32'h0);

    start_cycle(); rename(6'd1, 4'd1);
    start_cycle(); rename(6'd2, 4'd2); query("tag_x1", 6'd1, NR, 5'd1, 32'h0, ND, 32'h0);
    start_cycle(); pj = 1'b0; rename(6'd3, 4'd8); commit(4'd2, 6'd10, 32'h77);
                   query("flush_cycle", 6'd1, 6'd10, 5'd1, 32'h0, ND, 32'h0);
    start_cycle(); query("flushed_x1_x2", 6'd1, 6'd2, ND, 32'h0, ND, 32'h0);
    start_cycle(); query("flush_x3_x10", 6'd3, 6'd10, ND, 32'h0, ND, 32'h77);
    start_cycle(); query("flush_x7_x9", 6'd7, 6'd9, ND, 32'hBB, ND, 32'h55);

    start_cycle(); rename(6'd0, 4'd7); commit(4'd0, 6'd0, 32'hFFFF);
    start_cycle(); rename(NR, 4'd7); commit(4'd0, NR, 32'hFFFF);
    start_cycle(); query("x0_nonreg", 6'd0, NR, ND, 32'h0, ND, 32'h0);

    start_cycle(); rdy = 1'b0; rename(6'd11, 4'd9); commit(4'd0, 6'd12, 32'h99);
                   query("rdy0_cycle", 6'd11, 6'd12, ND, 32'h0, ND, 32'h0);
    start_cycle(); query("rdy0_no_change", 6'd11, 6'd12, ND, 32'h0, ND, 32'h0);
    start_cycle(); rename(6'd13, 4'd10);
    start_cycle(); rdy = 1'b0; commit(4'd10, 6'd13, 32'h13);
                   query("rdy0_bypass_live", 6'd13, NR, ND, 32'h13, ND, 32'h0);
    start_cycle(); query("rdy0_commit_held", 6'd13, NR, 5'd10, 32'h0, ND, 32'h0);

    start_cycle(); rst = 1'b1; rdy = 1'b0;
    start_cycle(); query("reset_again", 6'd7, 6'd13, ND, 32'h0, ND, 32'h0);

    start_cycle();
    start_cycle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer and consumes its in-order commit stream.
- Holds 32 x 32-bit values plus, per register, the RoB index of the youngest in-flight producer.
- Serves the dispatcher combinationally (operand value or dependency tag).
- Records dispatcher renames; discards all tags on a branch-mispredict flush.

Parameters:
- REG_WIDTH, 5, architectural register index width
- EX_REG_WIDTH, 6, register field width incl. "no register" code
- NON_REG, 32, rd/rs code meaning "no register"
- RoB_WIDTH, 4, RoB index width
- EX_RoB_WIDTH, 5, tag width incl. "no dependency" code
- NON_DEP, 16, tag meaning "value valid in file"

Ports:
- Sys_clk  in  1  clock, all state updates on rising edge
- Sys_rst  in  1  synchronous active-high reset
- Sys_rdy  in  1  global enable; when low all state holds
- DPRF_rs1  in  EX_REG_WIDTH  source 1 query
- DPRF_rs2  in  EX_REG_WIDTH  source 2 query
- RFDP_Qj  out  EX_RoB_WIDTH  tag for rs1 (NON_DEP if ready)
- RFDP_Qk  out  EX_RoB_WIDTH  tag for rs2
- RFDP_Vj  out  32  value for rs1 (valid when RFDP_Qj==NON_DEP)
- RFDP_Vk  out  32  value for rs2
- DPRF_en  in  1  rename request this cycle
- DPRF_rd  in  EX_REG_WIDTH  destination being renamed
- DPRF_RoB_index  in  RoB_WIDTH  RoB slot of renaming instruction
- RoBRF_pre_judge  in  1  0 = mispredict flush this cycle
- RoBRF_en  in  1  commit valid
- RoBRF_RoB_index  in  RoB_WIDTH  RoB slot being committed
- RoBRF_rd  in  EX_REG_WIDTH  committed destination
- RoBRF_value  in  32  committed result

Behaviour:
- State: value[0..31] (32b), tag[0..31] (EX_RoB_WIDTH).
- Reset (Sys_rst=1 at edge, regardless of Sys_rdy): all value=0, all tag=NON_DEP. Outputs are combinational, so after reset any query gives Q=NON_DEP, V=0.
- x0 and NON_REG:
  - Query of x0 or NON_REG: Q=NON_DEP, V=0.
  - Writes and renames to x0 or NON_REG are ignored.
- Query (combinational, zero latency) for register r:
  - If tag[r]==NON_DEP: Q=NON_DEP, V=value[r].
  - Else if RoBRF_en && RoBRF_rd==r && tag[r]=={0,RoBRF_RoB_index}: bypass, Q=NON_DEP, V=RoBRF_value.
  - Else: Q=tag[r], V=0.
  - Queries never observe a same-cycle rename; sources are read before the instruction's own rd is renamed.
- Commit (edge, Sys_rdy=1, RoBRF_en=1, rd valid nonzero):
  - value[rd] <= RoBRF_value.
  - tag[rd] <= NON_DEP only if tag[rd]=={0,RoBRF_RoB_index}; a younger producer's tag is kept.
- Rename (edge, Sys_rdy=1, DPRF_en=1, RoBRF_pre_judge=1, rd valid nonzero): tag[rd] <= {0,DPRF_RoB_index}.
- Commit and rename to the same rd in one cycle: rename wins on tag; value still written by commit.
- Flush (edge, Sys_rdy=1, RoBRF_pre_judge=0):
  - All tags <= NON_DEP.
  - Rename ignored.
  - A commit presented the same cycle still writes its value, since committed work is architectural.
- Sys_rdy=0 (no reset): no state change; combinational outputs still valid.
- Single-cycle update; no internal FSM beyond per-register tag valid/pending state.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> Qj=16, Vj=0, Qk=16, Vk=0.
- Rename x5->RoB 3; next cycle query x5 -> Qj=3. Commit (idx 3, x5, 0x1234) -> next cycle Qj=16, Vj=0x1234.
- Tag 3 on x7, commit (3, x7, 0xAA) while querying x7 same cycle -> Qj=16, Vj=0xAA (bypass).
- Rename x7->RoB 4, then commit (3, x7, 0xBB) -> value[x7]=0xBB, tag stays 4; query gives Q=4.
- Same cycle: rename x9->RoB 6 and commit (5, x9, 0x55) with tag[x9]=5 -> tag=6, value=0x55.
- Tags on x1,x2 pending; pre_judge=0 with DPRF_en (x3->RoB 8) and commit (idx 2, x10, 0x77) -> all Q=16, x3 not tagged, value[x10]=0x77.
- Rename x0 and commit (x0, 0xFFFF) -> query x0 gives Q=16, V=0.
- Sys_rdy=0 during a rename/commit -> no state change observed.
